cp0_regfile: RTL and testbench
==============================

Name: cp0_regfile

Overview:
- MIPS coprocessor-0 state block directly downstream of the exception unit.
- Consumes the committed exception record and ERET indication, and services MTC0/MFC0.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC, and runs the Count/Compare timer.
- Feeds back the interrupt request vector and Status bits the exception unit uses to qualify interrupts.

Parameters:
- COUNT_DIV, 2, Count increments once every COUNT_DIV cycles; legal values 1 or 2.
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- exc_valid  in  1  committed exception this cycle
- exc_pc  in  32  PC of the faulting instruction
- exc_in_delay_slot  in  1  faulting instruction is in a branch delay slot
- exc_code  in  5  ExcCode (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12)
- exc_badvaddr  in  32  faulting virtual address
- is_eret  in  1  ERET committing this cycle
- ext_int  in  6  hardware interrupt lines, level sensitive
- wen  in  1  MTC0 write enable
- waddr  in  5  MTC0 register number
- wdata  in  32  MTC0 data
- raddr  in  5  MFC0 register number
- rdata  out  32  MFC0 data, combinational from current state
- epc  out  32  current EPC
- status_ie  out  1  Status.IE
- status_exl  out  1  Status.EXL
- status_erl  out  1  Status.ERL
- interrupt_info  out  8  Cause.IP & Status.IM

Behaviour:
- Clock and reset: one clock `clk`; reset `resetn` is synchronous and active-low. All state updates occur on the rising edge of `clk`.
- Reset values:
  - Status = STATUS_RST.
  - Cause = 0, EPC = 0, BadVAddr = 0, Count = 0, Compare = 0.
  - Timer-interrupt flag TI = 0; divider phase = 0.
  - Outputs after reset: rdata follows raddr; interrupt_info = 0.
- Register map:
  - BadVAddr = 8, Count = 9, Compare = 11, Status = 12, Cause = 13, EPC = 14.
  - All other raddr values read 0; writes to them are ignored.
- Writable fields:
  - Status: IM[15:8], EXL[1], IE[0]. BEV and ERL are read-only.
  - Cause: IP[9:8] only.
  - EPC, Count, Compare: all 32 bits.
  - BadVAddr: read-only via MTC0.
- Write timing: every update is visible on rdata and the outputs in the next cycle. There is no same-cycle bypass.
- Cause read composition:
  - Cause[31] = BD.
  - Cause[30] = TI.
  - Cause[15:10] = {ext_int[5] | TI, ext_int[4:0]}, sampled into the register every cycle.
  - Cause[9:8] = software IP.
  - Cause[6:2] = ExcCode.
- Exception entry, when exc_valid=1:
  - If EXL=0: EPC <= exc_in_delay_slot ? exc_pc-4 : exc_pc, and BD <= exc_in_delay_slot.
  - If EXL=1: EPC and BD are left unchanged.
  - Always: EXL <= 1 and ExcCode <= exc_code.
  - BadVAddr <= exc_badvaddr only when exc_code is 4 or 5.
- ERET: when is_eret=1 and exc_valid=0, EXL <= 0.
- Priority within one cycle: exc_valid > is_eret > MTC0.
  - An MTC0 to Status or Cause in the same cycle as an exception or ERET is dropped for the fields that event writes.
  - An MTC0 to EPC in the same cycle as an exception with EXL=0 is dropped.
- Timer:
  - Divider phase toggles every cycle (COUNT_DIV=2). Count += 1 when the phase is 1, wrapping at 2^32-1 to 0.
  - MTC0 to Count loads wdata and resets the phase to 0.
  - TI is set the cycle after Count == Compare and Compare != 0, and stays set until an MTC0 to Compare (which clears TI).
- interrupt_info = {IP7..IP2, IP1..IP0} & Status.IM, taken from registered Cause.
- Reset asserted mid-operation discards any pending write or exception.

Optional Feature:
- Macro: CP0_TIMER_EN.
- Defined: Count/Compare/TI behave as above.
- Undefined:
  - Count and Compare read 0 and writes to them are ignored.
  - TI is constant 0, so Cause[30]=0 and IP7 = ext_int[5] only.
  - Divider logic is absent.

Test Plan:
- Reset, then raddr=12 -> rdata=32'h0040_0000. Reset, then raddr=13 -> rdata=0; interrupt_info=0.
- exc_valid, exc_pc=0xBFC0_0100, exc_in_delay_slot=1, exc_code=4, exc_badvaddr=0x1234_5671 -> next cycle:
  - EPC=0xBFC0_00FC, Cause.BD=1, ExcCode=4, BadVAddr=0x1234_5671, status_exl=1.
  - A second exception with pc=0x8000_0000 leaves EPC unchanged.
- With EXL=1, is_eret=1 -> status_exl=0 next cycle. Then exc_valid and is_eret in the same cycle -> status_exl=1.
- MTC0 Status=0x0000_FF01, MTC0 Cause=0x100 -> interrupt_info=0x01. Then ext_int=6'b000100 -> interrupt_info=0x11 the cycle after.
- MTC0 Count=0, Compare=5 -> TI=1 and Cause[30]=1 about 11 cycles later, with interrupt_info[7]=1 when IM7=1. MTC0 Compare=9 -> TI=0 next cycle.
- MTC0 Count=0xFFFF_FFFF -> Count reads 0 after two cycles. Same-cycle MTC0 EPC=0x1 with an exception at pc=0x400 and EXL=0 -> EPC=0x400.

Source files
------------

// File: rtl/cp0_regfile.sv
// MIPS CP0 state: BadVAddr, Count, Compare, Status, Cause, EPC plus the Count/Compare timer.
// Define CP0_TIMER_EN to build the timer; without it Count/Compare read 0 and TI is tied low.
`timescale 1ns/1ps
module cp0_regfile #(
   parameter int          COUNT_DIV  = 2,
   parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        exc_valid,
   input  logic [31:0] exc_pc,
   input  logic        exc_in_delay_slot,
   input  logic [4:0]  exc_code,
   input  logic [31:0] exc_badvaddr,
   input  logic        is_eret,
   input  logic [5:0]  ext_int,
   input  logic        wen,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr,
   output logic [31:0] rdata,
   output logic [31:0] epc,
   output logic        status_ie,
   output logic        status_exl,
   output logic        status_erl,
   output logic [7:0]  interrupt_info
);
   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;

   logic [7:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [5:0]  ip_hw_q, ip_hw_d;
   logic [1:0]  ip_sw_q, ip_sw_d;
   logic [4:0]  exc_code_q, exc_code_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] badvaddr_q, badvaddr_d;
   logic        ti;
   logic [31:0] count_rd, compare_rd;
   logic [31:0] status_rd, cause_rd;

`ifdef CP0_TIMER_EN
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        ti_q, ti_d;
   logic        phase_q, phase_d;
   logic        count_inc;

   assign ti         = ti_q;
   assign count_rd   = count_q;
   assign compare_rd = compare_q;

   always_comb begin
      count_d   = count_q;
      compare_d = compare_q;
      ti_d      = ti_q;
      phase_d   = ~phase_q;
      count_inc = (COUNT_DIV == 1) ? 1'b1 : phase_q;
      if (count_inc)
         count_d = count_q + 32'd1;
      if ((count_q == compare_q) && (compare_q != 32'd0))
         ti_d = 1'b1;
      if (wen && (waddr == REG_COUNT)) begin
         count_d = wdata;
         phase_d = 1'b0;
      end
      if (wen && (waddr == REG_COMPARE)) begin
         compare_d = wdata;
         ti_d      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         count_q   <= 32'd0;
         compare_q <= 32'd0;
         ti_q      <= 1'b0;
         phase_q   <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
         phase_q   <= phase_d;
      end
   end
`else
   logic unused_div;
   assign unused_div = (COUNT_DIV == 1);
   assign ti         = 1'b0;
   assign count_rd   = 32'd0;
   assign compare_rd = 32'd0;
`endif

   // Later assignments win: exception overrides ERET, which overrides MTC0.
   always_comb begin
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ip_sw_d    = ip_sw_q;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;
      badvaddr_d = badvaddr_q;
      ip_hw_d    = {ext_int[5] | ti, ext_int[4:0]};
      if (wen) begin
         case (waddr)
            REG_STATUS: begin
               im_d  = wdata[15:8];
               exl_d = wdata[1];
               ie_d  = wdata[0];
            end
            REG_CAUSE: ip_sw_d = wdata[9:8];
            REG_EPC:   epc_d   = wdata;
            default:   ;
         endcase
      end
      if (exc_valid) begin
         exl_d      = 1'b1;
         exc_code_d = exc_code;
         if (!exl_q) begin
            epc_d = exc_in_delay_slot ? (exc_pc - 32'd4) : exc_pc;
            bd_d  = exc_in_delay_slot;
         end
         if ((exc_code == 5'd4) || (exc_code == 5'd5))
            badvaddr_d = exc_badvaddr;
      end else if (is_eret) begin
         exl_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         im_q       <= STATUS_RST[15:8];
         exl_q      <= STATUS_RST[1];
         ie_q       <= STATUS_RST[0];
         bd_q       <= 1'b0;
         ip_hw_q    <= 6'd0;
         ip_sw_q    <= 2'd0;
         exc_code_q <= 5'd0;
         epc_q      <= 32'd0;
         badvaddr_q <= 32'd0;
      end else begin
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ip_hw_q    <= ip_hw_d;
         ip_sw_q    <= ip_sw_d;
         exc_code_q <= exc_code_d;
         epc_q      <= epc_d;
         badvaddr_q <= badvaddr_d;
      end
   end

   always_comb begin
      status_rd = {STATUS_RST[31:16], im_q, STATUS_RST[7:2], exl_q, ie_q};
      cause_rd  = {bd_q, ti, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exc_code_q, 2'b00};
      rdata     = 32'd0;
      case (raddr)
         REG_BADVADDR: rdata = badvaddr_q;
         REG_COUNT:    rdata = count_rd;
         REG_COMPARE:  rdata = compare_rd;
         REG_STATUS:   rdata = status_rd;
         REG_CAUSE:    rdata = cause_rd;
         REG_EPC:      rdata = epc_q;
         default:      rdata = 32'd0;
      endcase
   end

   assign epc            = epc_q;
   assign status_ie      = ie_q;
   assign status_exl     = exl_q;
   assign status_erl     = STATUS_RST[2];
   assign interrupt_info = {ip_hw_q, ip_sw_q} & im_q;
endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile; timer section follows the CP0_TIMER_EN build option.
`timescale 1ns/1ps
module tb_cp0_regfile;
   logic        clk = 1'b0;
   logic        resetn;
   logic        exc_valid;
   logic [31:0] exc_pc;
   logic        exc_in_delay_slot;
   logic [4:0]  exc_code;
   logic [31:0] exc_badvaddr;
   logic        is_eret;
   logic [5:0]  ext_int;
   logic        wen;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr;
   logic [31:0] rdata;
   logic [31:0] epc;
   logic        status_ie, status_exl, status_erl;
   logic [7:0]  interrupt_info;

   int checks = 0;
   int errors = 0;

   cp0_regfile dut (
      .clk(clk), .resetn(resetn), .exc_valid(exc_valid), .exc_pc(exc_pc),
      .exc_in_delay_slot(exc_in_delay_slot), .exc_code(exc_code),
      .exc_badvaddr(exc_badvaddr), .is_eret(is_eret), .ext_int(ext_int),
      .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata),
      .epc(epc), .status_ie(status_ie), .status_exl(status_exl),
      .status_erl(status_erl), .interrupt_info(interrupt_info)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
      raddr = a;
      #1;
      chk(tag, rdata, exp);
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      wen = 1'b1; waddr = a; wdata = d;
      cyc();
      wen = 1'b0;
   endtask

   task automatic exc(input logic [31:0] pc, input logic ds, input logic [4:0] code,
                      input logic [31:0] badv);
      exc_valid = 1'b1; exc_pc = pc; exc_in_delay_slot = ds;
      exc_code = code; exc_badvaddr = badv;
      cyc();
      exc_valid = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; exc_valid = 1'b0; exc_pc = '0; exc_in_delay_slot = 1'b0;
      exc_code = '0; exc_badvaddr = '0; is_eret = 1'b0; ext_int = '0;
      wen = 1'b0; waddr = '0; wdata = '0; raddr = '0;
      cyc(); cyc();
      resetn = 1'b1;

      rd("rst_status", 5'd12, 32'h0040_0000);
      rd("rst_cause", 5'd13, 32'h0);
      rd("rst_count", 5'd9, 32'h0);
      chk("rst_intinfo", {24'd0, interrupt_info}, 32'h0);
      chk("rst_exl", {31'd0, status_exl}, 32'h0);
      chk("rst_epc", epc, 32'h0);

      exc(32'hBFC0_0100, 1'b1, 5'd4, 32'h1234_5671);
      chk("exc1_epc", epc, 32'hBFC0_00FC);
      chk("exc1_exl", {31'd0, status_exl}, 32'h1);
      rd("exc1_cause", 5'd13, 32'h8000_0010);
      rd("exc1_badv", 5'd8, 32'h1234_5671);

      exc(32'h8000_0000, 1'b0, 5'd8, 32'h0000_DEAD);
      chk("exc2_epc_hold", epc, 32'hBFC0_00FC);
      rd("exc2_badv_hold", 5'd8, 32'h1234_5671);
      rd("exc2_cause", 5'd13, 32'h8000_0020);

      is_eret = 1'b1; cyc(); is_eret = 1'b0;
      chk("eret_exl", {31'd0, status_exl}, 32'h0);
      is_eret = 1'b1;
      exc(32'h0000_0100, 1'b0, 5'd12, 32'h0);
      is_eret = 1'b0;
      chk("exc_eret_exl", {31'd0, status_exl}, 32'h1);
      chk("exc_eret_epc", epc, 32'h0000_0100);
      rd("exc_eret_cause", 5'd13, 32'h0000_0030);
      is_eret = 1'b1; cyc(); is_eret = 1'b0;

      mtc0(5'd12, 32'hFFFF_FFFF);
      rd("status_mask", 5'd12, 32'h0040_FF03);
      chk("status_erl", {31'd0, status_erl}, 32'h0);
      chk("status_exl_wr", {31'd0, status_exl}, 32'h1);
      mtc0(5'd12, 32'h0000_FF01);
      rd("status_wr", 5'd12, 32'h0040_FF01);
      chk("status_ie", {31'd0, status_ie}, 32'h1);
      mtc0(5'd13, 32'hFFFF_FFFF);
      rd("cause_mask", 5'd13, 32'h0000_0330);
      mtc0(5'd13, 32'h0000_0100);
      chk("intinfo_sw", {24'd0, interrupt_info}, 32'h01);
      ext_int = 6'b000100;
      cyc();
      chk("intinfo_hw", {24'd0, interrupt_info}, 32'h11);
      rd("cause_hw", 5'd13, 32'h0000_1130);
      ext_int = 6'b0;
      cyc();

      mtc0(5'd3, 32'hFFFF_FFFF);
      rd("unmapped", 5'd3, 32'h0);
      mtc0(5'd8, 32'hFFFF_FFFF);
      rd("badv_ro", 5'd8, 32'h1234_5671);
      mtc0(5'd14, 32'h0000_1234);
      chk("epc_wr", epc, 32'h0000_1234);

      wen = 1'b1; waddr = 5'd14; wdata = 32'h1;
      exc(32'h0000_0400, 1'b0, 5'd0, 32'h0);
      wen = 1'b0;
      chk("epc_prio", epc, 32'h0000_0400);
      is_eret = 1'b1; cyc(); is_eret = 1'b0;

`ifdef CP0_TIMER_EN
      mtc0(5'd9, 32'd100);
      mtc0(5'd11, 32'd5);
      mtc0(5'd9, 32'd0);
      repeat (10) cyc();
      rd("count_5", 5'd9, 32'd5);
      raddr = 5'd13; #1;
      chk("ti_pre", {31'd0, rdata[30]}, 32'h0);
      cyc();
      raddr = 5'd13; #1;
      chk("ti_set", {31'd0, rdata[30]}, 32'h1);
      cyc();
      chk("intinfo_ti", {24'd0, interrupt_info}, 32'h81);
      rd("cause_ti", 5'd13, 32'h4000_8100);
      mtc0(5'd11, 32'd9);
      raddr = 5'd13; #1;
      chk("ti_clr", {31'd0, rdata[30]}, 32'h0);
      mtc0(5'd9, 32'hFFFF_FFFF);
      rd("count_ld", 5'd9, 32'hFFFF_FFFF);
      cyc(); cyc();
      rd("count_wrap", 5'd9, 32'h0);
`else
      mtc0(5'd9, 32'd100);
      rd("count_off", 5'd9, 32'h0);
      mtc0(5'd11, 32'd5);
      rd("compare_off", 5'd11, 32'h0);
      repeat (12) cyc();
      rd("cause_noti", 5'd13, 32'h0000_0100);
`endif

      resetn = 1'b0;
      wen = 1'b1; waddr = 5'd12; wdata = 32'h0000_FF03;
      exc(32'h0000_0700, 1'b0, 5'd4, 32'hFFFF_0000);
      resetn = 1'b1; wen = 1'b0;
      rd("mrst_status", 5'd12, 32'h0040_0000);
      rd("mrst_cause", 5'd13, 32'h0);
      rd("mrst_badv", 5'd8, 32'h0);
      chk("mrst_epc", epc, 32'h0);
      chk("mrst_intinfo", {24'd0, interrupt_info}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
